// File: rtl/yarvi_tx_arbiter_pkg.sv
// Shared definitions for the yarvi host tx byte-channel arbiter:
// requester indices, FSM encoding and the round-robin pointer helper.
package yarvi_tx_arbiter_pkg;

  localparam int unsigned NREQ_MAX    = 8;
  localparam int unsigned GRANT_W     = 3;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned REQ_CONSOLE = 0;
  localparam int unsigned REQ_TRACE   = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Next round-robin start position after idx, wrapping at n requesters
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                 input int unsigned       n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/yarvi_tx_arbiter_if.sv
// Requester byte channels plus the single host tx channel.
// The arbiter is the master of the host link and sinks the requester bytes.
interface yarvi_tx_arbiter_if
  import yarvi_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]        req_valid;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   tx_valid;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/yarvi_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted valid at or after ptr_i,
// wrapping modulo NREQ.
module yarvi_tx_arbiter_rr_pick
  import yarvi_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]    valid_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic               found_o,
  output logic [GRANT_W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest valid wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (valid_i[i] && (i == ((int'(ptr_i) + k) % int'(NREQ)))) begin
          found_o = 1'b1;
          idx_o   = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/yarvi_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the host tx byte channel among
// NREQ requesters, with a registered output slot and stalled-packet timeout.
module yarvi_tx_arbiter
  import yarvi_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 16
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  yarvi_tx_arbiter_if.master bus,
  output logic [GRANT_W-1:0] grant_id_o,
  output logic               locked_o,
  output logic [TW-1:0]      abort_cnt_o
);

  state_e              state_q;
  logic                tx_valid_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic [GRANT_W-1:0]  grant_q;
  logic [GRANT_W-1:0]  rr_q;
  logic [TW-1:0]       to_cnt_q;
  logic [TW-1:0]       abort_q;

  logic                slot_free;
  logic                found;
  logic [GRANT_W-1:0]  pick_idx;
  logic [GRANT_W-1:0]  acc_idx;
  logic [BYTE_W-1:0]   acc_data;
  logic                acc_last;
  logic                gnt_valid;
  logic                ready_en;
  logic [NREQ-1:0]     ready;
  logic                accept;

  yarvi_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_q),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  assign slot_free = !tx_valid_q || bus.tx_ready;

  // Candidate requester: fresh pick when idle, locked owner otherwise
  always_comb begin
    acc_idx   = (state_q == ST_IDLE) ? pick_idx : grant_q;
    acc_data  = '0;
    acc_last  = 1'b0;
    gnt_valid = 1'b0;
    ready_en  = reset_ni && slot_free && ((state_q == ST_IDLE) ? found : 1'b1);
    ready     = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (acc_idx == GRANT_W'(i)) begin
        acc_data = bus.req_data[BYTE_W*i +: BYTE_W];
        acc_last = bus.req_last[i];
        ready[i] = ready_en;
      end
      if (grant_q == GRANT_W'(i)) begin
        gnt_valid = bus.req_valid[i];
      end
    end
  end

  assign accept        = |(ready & bus.req_valid);
  assign bus.req_ready = ready;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      to_cnt_q   <= '0;
      abort_q    <= '0;
    end else begin
      if (accept) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= acc_data;
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_q  <= acc_idx;
            to_cnt_q <= '0;
            if (acc_last) rr_q    <= rr_next(acc_idx, NREQ);
            else          state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            to_cnt_q <= '0;
            if (acc_last) begin
              state_q <= ST_IDLE;
              rr_q    <= rr_next(grant_q, NREQ);
            end
          end else if (slot_free && !gnt_valid) begin
            // Only owner silence counts; a host stall never ages the lock
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
              state_q  <= ST_IDLE;
              rr_q     <= rr_next(grant_q, NREQ);
              to_cnt_q <= '0;
              if (abort_q != '1) abort_q <= abort_q + TW'(1);
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign grant_id_o   = grant_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign abort_cnt_o  = abort_q;

endmodule

// File: tb/tb_yarvi_tx_arbiter.sv
// Scenario bench for yarvi_tx_arbiter: per-requester source queues feed the
// DUT and an expected-byte queue is checked as the host accepts bytes.
module tb_yarvi_tx_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TW      = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    grant_id;
  logic          locked;
  logic [TW-1:0] abort_cnt;

  always #5 clk = ~clk;

  yarvi_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  yarvi_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .bus         (bus),
    .grant_id_o  (grant_id),
    .locked_o    (locked),
    .abort_cnt_o (abort_cnt)
  );

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         host_rdy = 1'b1;

  task automatic drive();
    bus.req_valid[0]  = (src0.size() > 0);
    bus.req_data[7:0] = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
    bus.req_last[0]   = (src0.size() > 0) ? src0[0][8] : 1'b0;
    bus.req_valid[1]  = (src1.size() > 0);
    bus.req_data[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
    bus.req_last[1]   = (src1.size() > 0) ? src1[0][8] : 1'b0;
    bus.tx_ready      = host_rdy;
  endtask

  // One cycle: score host transfer and note requester handshakes at negedge
  task automatic step(input bit chk_blk0);
    bit         f0, f1;
    logic [7:0] e;
    @(negedge clk);
    if (bus.tx_valid && bus.tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %02h, expected %02h", bus.tx_data, e);
        end
      end
    end
    if (chk_blk0 && locked) begin
      checks++;
      if (bus.req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL no_interleave_ready0: got %b, expected 0", bus.req_ready[0]);
      end
    end
    f0 = bus.req_valid[0] & bus.req_ready[0];
    f1 = bus.req_valid[1] & bus.req_ready[1];
    @(posedge clk);
    #1;
    if (f0) void'(src0.pop_front());
    if (f1) void'(src1.pop_front());
    drive();
  endtask

  task automatic run_until_empty(input int budget, output int cycles);
    cycles = 0;
    while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && cycles < budget) begin
      step(1'b0);
      cycles++;
    end
    checks++;
    if (exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles, expected 0",
               exp_q.size(), cycles);
    end
  endtask

  task automatic apply_reset();
    src0.delete();
    src1.delete();
    exp_q.delete();
    host_rdy = 1'b1;
    rst_n    = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n    = 1'b0;
    host_rdy = 1'b1;
    src0.push_back({1'b1, 8'h10});
    src1.push_back({1'b1, 8'h20});
    drive();
    repeat (4) begin
      @(negedge clk);
      chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("reset_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    step(1'b0);
    chk("reset_first_grant", 32'(grant_id), 32'd0);
    run_until_empty(20, c);
    chk("reset_second_grant", 32'(grant_id), 32'd1);
  endtask

  task automatic test_fairness();
    int c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back({1'b1, 8'hA0 + 8'(i)});
      src1.push_back({1'b1, 8'hB0 + 8'(i)});
      exp_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'hB0 + 8'(i));
    end
    drive();
    run_until_empty(40, c);
    chk("fair_gapless_cycles", 32'(c), 32'd9);
  endtask

  task automatic test_no_interleave();
    int guard;
    apply_reset();
    src1.push_back({1'b0, 8'h11});
    src1.push_back({1'b0, 8'h12});
    src1.push_back({1'b1, 8'h13});
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h55);
    drive();
    step(1'b0);
    chk("nil_locked", 32'(locked), 32'd1);
    chk("nil_grant", 32'(grant_id), 32'd1);
    src0.push_back({1'b1, 8'h55});
    drive();
    guard = 0;
    while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && guard < 20) begin
      step(1'b1);
      guard++;
    end
    chk("nil_drained", 32'(exp_q.size() + src0.size()), 32'd0);
    chk("nil_final_grant", 32'(grant_id), 32'd0);
  endtask

  task automatic test_backpressure();
    int c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back({1'b1, 8'hC0 + 8'(i)});
      exp_q.push_back(8'hC0 + 8'(i));
    end
    drive();
    step(1'b0);
    step(1'b0);
    host_rdy = 1'b0;
    drive();
    repeat (5) begin
      @(negedge clk);
      chk("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
      chk("bp_tx_data_held", 32'(bus.tx_data), 32'hC1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    host_rdy = 1'b1;
    drive();
    run_until_empty(30, c);
    step(1'b0);
    chk("bp_tx_idle_after", 32'(bus.tx_valid), 32'd0);
  endtask

  task automatic test_timeout();
    int c;
    apply_reset();
    src0.push_back({1'b0, 8'h01});
    src1.push_back({1'b1, 8'h77});
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h77);
    drive();
    step(1'b0);
    chk("to_locked_start", 32'(locked), 32'd1);
    chk("to_grant_start", 32'(grant_id), 32'd0);
    repeat (TIMEOUT - 1) step(1'b0);
    chk("to_still_locked", 32'(locked), 32'd1);
    chk("to_no_abort_yet", 32'(abort_cnt), 32'd0);
    step(1'b0);
    chk("to_released", 32'(locked), 32'd0);
    chk("to_abort_cnt", 32'(abort_cnt), 32'd1);
    step(1'b0);
    chk("to_next_grant", 32'(grant_id), 32'd1);
    run_until_empty(10, c);
  endtask

  task automatic test_reset_mid_packet();
    int c;
    apply_reset();
    src0.push_back({1'b0, 8'hD1});
    src0.push_back({1'b0, 8'hD2});
    src0.push_back({1'b0, 8'hD3});
    src0.push_back({1'b1, 8'hD4});
    exp_q.push_back(8'hD1);
    drive();
    step(1'b0);
    step(1'b0);
    chk("rm_locked_before", 32'(locked), 32'd1);
    chk("rm_inflight_valid", 32'(bus.tx_valid), 32'd1);
    rst_n    = 1'b0;
    host_rdy = 1'b0;
    src0.delete();
    drive();
    @(posedge clk);
    #1;
    chk("rm_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rm_locked", 32'(locked), 32'd0);
    chk("rm_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    host_rdy = 1'b1;
    src1.push_back({1'b1, 8'h99});
    exp_q.push_back(8'h99);
    drive();
    run_until_empty(10, c);
    chk("rm_new_grant", 32'(grant_id), 32'd1);
    chk("rm_unlocked_after", 32'(locked), 32'd0);
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
